// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: opcodes, ALU/writeback selectors, immediate
// formats and the ID/EX pipeline register layout.
package rv32i_pkg;

  localparam int XLEN_W = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] rs1_data;
    logic [XLEN_W-1:0] rs2_data;
    logic [XLEN_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    alu_op_t           alu_op;
    logic              alu_src_a;
    logic              alu_src_b;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              branch;
    logic              jump;
    wb_sel_t           wb_sel;
    logic              illegal;
  } id_ex_t;

  // Formats without an immediate (R-type, FENCE, SYSTEM, illegal) yield 0.
  function automatic logic [XLEN_W-1:0] imm_gen(input logic [31:0] instr,
                                                input imm_type_t   t);
    logic [XLEN_W-1:0] imm;
    imm = '0;
    case (t)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // OP-IMM only honours instr[30] for the right shift; OP also uses it for SUB.
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic b30,
                                          input logic is_op);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_op && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 2-read / 1-write register file with x0 hardwired to zero and an optional
// write-through path so a same-cycle writeback is visible to readers.
module reg_file #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int AW        = $clog2(NUM_REGS),
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            wr_en;

  assign wr_en = we_i && (wa_i != '0);

  // Storage: async clear, write on enabled non-x0 writeback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Read ports: x0 is zero, then bypass, then stored value.
  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (WB_BYPASS && wr_en && (wa_i == ra1_i)) rd1_o = wd_i;
    if (WB_BYPASS && wr_en && (wa_i == ra2_i)) rd2_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
    if (ra2_i == '0) rd2_o = '0;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register read, control decode, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            valid_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic [3:0]      alu_op_o,
  output logic            alu_src_a_o,
  output logic            alu_src_b_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            reg_write_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic [1:0]      wb_sel_o,
  output logic            illegal_o
);

  id_ex_t          id_ex_d, id_ex_q, dec;
  imm_type_t       imm_t;
  logic [XLEN-1:0] rs1_rdata, rs2_rdata;
  logic            rs1_used, rs2_used, load_use;

  reg_file #(
    .XLEN      (XLEN),
    .NUM_REGS  (NUM_REGS),
    .AW        (5),
    .WB_BYPASS (WB_BYPASS)
  ) u_reg_file (
    .clk     (clk),
    .reset_n (reset_n),
    .ra1_i   (instr_i[19:15]),
    .ra2_i   (instr_i[24:20]),
    .rd1_o   (rs1_rdata),
    .rd2_o   (rs2_rdata),
    .we_i    (wb_en_i),
    .wa_i    (wb_rd_i),
    .wd_i    (wb_data_i)
  );

  // Decode the instruction in ID into a candidate ID/EX entry.
  always_comb begin
    dec          = '0;
    imm_t        = IMM_NONE;
    rs1_used     = 1'b1;
    rs2_used     = 1'b0;
    dec.valid    = 1'b1;
    dec.pc       = pc_i;
    dec.rs1_data = rs1_rdata;
    dec.rs2_data = rs2_rdata;
    dec.rs1      = instr_i[19:15];
    dec.rs2      = instr_i[24:20];
    dec.rd       = instr_i[11:7];
    dec.funct3   = instr_i[14:12];
    dec.alu_op   = ALU_ADD;
    dec.wb_sel   = WB_ALU;
    case (instr_i[6:0])
      OPC_LUI: begin
        imm_t = IMM_U; rs1_used = 1'b0;
        dec.alu_op = ALU_PASSB; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        imm_t = IMM_U; rs1_used = 1'b0;
        dec.alu_src_a = 1'b1; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        imm_t = IMM_J; rs1_used = 1'b0;
        dec.jump = 1'b1; dec.wb_sel = WB_PC4; dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        imm_t = IMM_I;
        dec.jump = 1'b1; dec.alu_src_b = 1'b1; dec.wb_sel = WB_PC4; dec.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        imm_t = IMM_B; rs2_used = 1'b1;
        dec.branch = 1'b1; dec.alu_op = ALU_SUB;
      end
      OPC_LOAD: begin
        imm_t = IMM_I;
        dec.mem_read = 1'b1; dec.alu_src_b = 1'b1; dec.wb_sel = WB_MEM; dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        imm_t = IMM_S; rs2_used = 1'b1;
        dec.mem_write = 1'b1; dec.alu_src_b = 1'b1;
      end
      OPC_OPIMM: begin
        imm_t = IMM_I;
        dec.alu_op = alu_from_f3(instr_i[14:12], instr_i[30], 1'b0);
        dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_OP: begin
        rs2_used = 1'b1;
        dec.alu_op = alu_from_f3(instr_i[14:12], instr_i[30], 1'b1);
        dec.reg_write = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = imm_gen(instr_i, imm_t);
  end

  // Load-use: the load now in EX produces a register the ID instruction reads.
  always_comb begin
    load_use = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) && valid_i &&
               ((rs1_used && (id_ex_q.rd == instr_i[19:15])) ||
                (rs2_used && (id_ex_q.rd == instr_i[24:20])));
    stall_o  = load_use && !flush_i;
  end

  // Next ID/EX contents: flush beats hold, hold beats the hazard bubble.
  always_comb begin
    id_ex_d = id_ex_q;
    if (flush_i)                 id_ex_d = '0;
    else if (hold_i)             id_ex_d = id_ex_q;
    else if (load_use || !valid_i) id_ex_d = '0;
    else                         id_ex_d = dec;
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) id_ex_q <= '0;
    else          id_ex_q <= id_ex_d;
  end

  assign valid_o     = id_ex_q.valid;
  assign pc_o        = id_ex_q.pc;
  assign rs1_data_o  = id_ex_q.rs1_data;
  assign rs2_data_o  = id_ex_q.rs2_data;
  assign imm_o       = id_ex_q.imm;
  assign rs1_o       = id_ex_q.rs1;
  assign rs2_o       = id_ex_q.rs2;
  assign rd_o        = id_ex_q.rd;
  assign funct3_o    = id_ex_q.funct3;
  assign alu_op_o    = id_ex_q.alu_op;
  assign alu_src_a_o = id_ex_q.alu_src_a;
  assign alu_src_b_o = id_ex_q.alu_src_b;
  assign mem_read_o  = id_ex_q.mem_read;
  assign mem_write_o = id_ex_q.mem_write;
  assign reg_write_o = id_ex_q.reg_write;
  assign branch_o    = id_ex_q.branch;
  assign jump_o      = id_ex_q.jump;
  assign wb_sel_o    = id_ex_q.wb_sel;
  assign illegal_o   = id_ex_q.illegal;

endmodule
